// File: rtl/iir_biquad_mac_if.sv
// Purpose : tap/result bundle between the tap-delay stage, the biquad MAC and its consumer.
// Latency : none (wires only).
// Backpr. : none; in_valid is a strobe, an overrun shows up on drop.
//
// Signals : in_valid, x0, x1, x2  - decimated taps and their strobe (source -> MAC)
//           y_out, out_valid      - filtered sample and its one-cycle strobe (MAC -> sink)
//           busy, drop            - MAC status (computation running / sticky overrun)
// Modports: master = tap source / result observer, slave = the MAC itself.
interface iir_biquad_mac_if #(
    parameter int DATA_W = 11
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] x0;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] y_out;
    logic                     out_valid;
    logic                     busy;
    logic                     drop;

    modport master (
        output in_valid, x0, x1, x2,
        input  y_out, out_valid, busy, drop
    );

    modport slave (
        input  in_valid, x0, x1, x2,
        output y_out, out_valid, busy, drop
    );
endinterface

// File: rtl/iir_biquad_mac.sv
// Purpose : direct-form-I biquad y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2 on one shared multiplier.
// Latency : in_valid at edge T -> out_valid after edge T+6 (T+4 in FIR-only build); one sample per 7 (5) cycles.
// Backpr. : none; in_valid while a sample is in flight is discarded and latched into sticky drop.
//
// Ports   : clk, reset (async, active-high), enb (global clock enable, all state holds when low)
//           b0, b1, b2, a1, a2 : static signed coefficients, COEF_FRAC fraction bits
//           bus (slave)        : taps in, y_out/out_valid/busy/drop out
// Build   : define IIR_FEEDBACK_EN for the full biquad (feedback terms and y1/y2 state);
//           without it the block is a 3-tap FIR and a1/a2 are ignored.
module iir_biquad_mac #(
    parameter int DATA_W    = 11,
    parameter int COEF_W    = 12,
    parameter int COEF_FRAC = 10,
    parameter int ACC_W     = 27
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enb,
    input  logic signed [COEF_W-1:0] b0,
    input  logic signed [COEF_W-1:0] b1,
    input  logic signed [COEF_W-1:0] b2,
    input  logic signed [COEF_W-1:0] a1,
    input  logic signed [COEF_W-1:0] a2,
    iir_biquad_mac_if.slave          bus
);

    localparam int PROD_W = DATA_W + COEF_W;

`ifdef IIR_FEEDBACK_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd2;
`endif

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state;
    logic [2:0]               idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] x0_q;
    logic signed [DATA_W-1:0] x1_q;
    logic signed [DATA_W-1:0] x2_q;
    logic signed [DATA_W-1:0] y_out_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     drop_q;

`ifdef IIR_FEEDBACK_EN
    // Output history. These only change in OUT, so they are stable for the
    // whole MAC phase and act as the snapshot taken when the taps are latched.
    logic signed [DATA_W-1:0] y1_q;
    logic signed [DATA_W-1:0] y2_q;
`else
    logic unused_coef;
    assign unused_coef = ^{a1, a2};
`endif

    // ------------------------------------------------------------------
    // Operand select for the shared multiplier
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] op_dat;
    logic signed [COEF_W-1:0] op_coef;
    logic                     op_neg;

    always_comb begin
        op_dat  = x0_q;
        op_coef = b0;
        op_neg  = 1'b0;
        case (idx)
            3'd0: begin
                op_dat  = x0_q;
                op_coef = b0;
            end
            3'd1: begin
                op_dat  = x1_q;
                op_coef = b1;
            end
            3'd2: begin
                op_dat  = x2_q;
                op_coef = b2;
            end
`ifdef IIR_FEEDBACK_EN
            3'd3: begin
                op_dat  = y1_q;
                op_coef = a1;
                op_neg  = 1'b1;
            end
            3'd4: begin
                op_dat  = y2_q;
                op_coef = a2;
                op_neg  = 1'b1;
            end
`endif
            default: begin
                op_dat  = x0_q;
                op_coef = b0;
                op_neg  = 1'b0;
            end
        endcase
    end

    // Full-precision product, sign-extended into the accumulator; the
    // feedback terms are subtracted rather than negating the coefficient so
    // a coefficient of -2048 cannot overflow.
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_next;

    assign prod     = PROD_W'(op_dat) * PROD_W'(op_coef);
    assign prod_ext = ACC_W'(prod);
    assign acc_next = op_neg ? (acc - prod_ext) : (acc + prod_ext);

    // ------------------------------------------------------------------
    // Round half toward +inf, then saturate to the DATA_W range
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  r_full;
    logic signed [DATA_W-1:0] y_sat;

    assign acc_rnd = acc + HALF;
    assign r_full  = acc_rnd >>> COEF_FRAC;

    always_comb begin
        y_sat = r_full[DATA_W-1:0];
        if (r_full > SAT_MAX) begin
            y_sat = SAT_MAX[DATA_W-1:0];
        end else if (r_full < SAT_MIN) begin
            y_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 3'd0;
            acc         <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
`ifdef IIR_FEEDBACK_EN
            y1_q        <= '0;
            y2_q        <= '0;
`endif
        end else if (enb) begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x0_q   <= bus.x0;
                        x1_q   <= bus.x1;
                        x2_q   <= bus.x2;
                        acc    <= '0;
                        idx    <= 3'd0;
                        busy_q <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        state <= OUT;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                OUT: begin
                    y_out_q     <= y_sat;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    idx         <= 3'd0;
                    state       <= IDLE;
`ifdef IIR_FEEDBACK_EN
                    y2_q        <= y1_q;
                    y1_q        <= y_sat;
`endif
                end
                default: begin
                    busy_q <= 1'b0;
                    idx    <= 3'd0;
                    state  <= IDLE;
                end
            endcase
            // A strobe in MAC or OUT is lost; remember that until reset.
            if (bus.in_valid && (state != IDLE)) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign bus.y_out     = y_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_iir_biquad_mac.sv
module tb_iir_biquad_mac;

    localparam int DW = 11;
    localparam int CW = 12;

`ifdef IIR_FEEDBACK_EN
    localparam int LAT      = 6;
    localparam int BUSY_CYC = 6;
`else
    localparam int LAT      = 4;
    localparam int BUSY_CYC = 4;
`endif

    typedef struct {
        int y;
        int cyc;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 enb;
    logic signed [CW-1:0] b0;
    logic signed [CW-1:0] b1;
    logic signed [CW-1:0] b2;
    logic signed [CW-1:0] a1;
    logic signed [CW-1:0] a2;

    iir_biquad_mac_if #(.DATA_W(DW)) bus ();

    iir_biquad_mac #(
        .DATA_W   (DW),
        .COEF_W   (CW),
        .COEF_FRAC(10),
        .ACC_W    (27)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .enb  (enb),
        .b0   (b0),
        .b1   (b1),
        .b2   (b2),
        .a1   (a1),
        .a2   (a2),
        .bus  (bus)
    );

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a negedge: the strobe is sampled at the next posedge (edge T).
    task automatic issue(input int xa, input int xb, input int xc,
                         input bit expect_out, input int yexp, input int extra);
        exp_t e;
        bus.x0       = DW'(xa);
        bus.x1       = DW'(xb);
        bus.x2       = DW'(xc);
        bus.in_valid = 1'b1;
        if (expect_out) begin
            e.y   = yexp;
            e.cyc = cyc + 1 + LAT + extra;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2, input int d1, input int d2);
        b0 = CW'(c0);
        b1 = CW'(c1);
        b2 = CW'(c2);
        a1 = CW'(d1);
        a2 = CW'(d2);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   busy_cnt;
        int   fb_exp[6];
        exp_t e;

        reset        = 1'b1;
        enb          = 1'b1;
        bus.in_valid = 1'b0;
        bus.x0       = '0;
        bus.x1       = '0;
        bus.x2       = '0;
        set_coef(1024, 0, 0, 0, 0);

        // Scoreboard monitor: pops one expectation per out_valid cycle.
        fork
            forever begin
                @(negedge clk);
                if (bus.out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("spurious_out_valid", int'(bus.out_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("y_out", int'(bus.y_out), e.y);
                        check("out_latency_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_y_out", int'(bus.y_out), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_drop", int'(bus.drop), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Passthrough, with busy width measured over the whole transaction.
        issue(8, 0, 0, 1'b1, 8, 0);
        busy_cnt = int'(bus.busy);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy);
        end
        check("busy_cycles", busy_cnt, BUSY_CYC);
        drain("drain_passthrough");

        // Rounding half toward +inf.
        set_coef(512, 0, 0, 0, 0);
        issue(3, 0, 0, 1'b1, 2, 0);
        drain("drain_round_pos");
        issue(-3, 0, 0, 1'b1, -1, 0);
        drain("drain_round_neg");

        // Saturation in both directions.
        set_coef(2047, 0, 0, 0, 0);
        issue(1023, 0, 0, 1'b1, 1023, 0);
        drain("drain_sat_pos");
        issue(-1024, 0, 0, 1'b1, -1024, 0);
        drain("drain_sat_neg");

        // Other taps: 0.5*x1 + 0.25*x2 = 50 + (-10).
        set_coef(0, 512, 256, 0, 0);
        issue(7, 100, -40, 1'b1, 40, 0);
        drain("drain_taps");
        check("drop_before_overrun", int'(bus.drop), 0);

        // Overrun: second strobe 3 cycles after the first is discarded.
        set_coef(1024, 0, 0, 0, 0);
        issue(20, 0, 0, 1'b1, 20, 0);
        repeat (2) @(negedge clk);
        issue(99, 0, 0, 1'b0, 0, 0);
        drain("drain_overrun");
        check("drop_set", int'(bus.drop), 1);
        repeat (10) @(negedge clk);
        check("drop_sticky", int'(bus.drop), 1);
        pulse_reset();
        check("drop_cleared", int'(bus.drop), 0);

        // Impulse through the feedback path (FIR build: plain impulse).
`ifdef IIR_FEEDBACK_EN
        fb_exp = '{16, 8, 4, 2, 1, 1};
`else
        fb_exp = '{16, 0, 0, 0, 0, 0};
`endif
        set_coef(1024, 0, 0, -512, 0);
        for (int k = 0; k < 6; k++) begin
            issue((k == 0) ? 16 : 0, 0, 0, 1'b1, fb_exp[k], 0);
            repeat (7) @(negedge clk);
        end
        drain("drain_feedback");
        pulse_reset();

        // Clock enable low for 4 cycles mid-MAC.
        set_coef(1024, 0, 0, 0, 0);
        issue(40, 0, 0, 1'b1, 40, 4);
        @(negedge clk);
        enb = 1'b0;
        repeat (4) @(negedge clk);
        enb = 1'b1;
        drain("drain_enb");
        check("y_out_hold", int'(bus.y_out), 40);

        // Reset mid-computation at T+3: abort with no result.
        issue(60, 0, 0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        check("busy_mid_mac", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_y_out", int'(bus.y_out), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_busy_after", int'(bus.busy), 0);
        check("abort_y_out_after", int'(bus.y_out), 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iir_biquad_mac.md
Name: iir_biquad_mac

Overview:
- Downstream consumer of the tap-delay stage: takes the three decimated input taps x[n], x[n-1], x[n-2] (sfix11_En3), produced once per slow-rate strobe.
- Computes one direct-form-I biquad output y[n] = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2 using a single time-multiplexed multiplier.
- Holds y[n-1] and y[n-2] internally.
- Result drives the next filter section or the output rate-transition stage.

Parameters:
- DATA_W, 11, signed data width of taps and y (fixed-point En3).
- COEF_W, 12, signed coefficient width.
- COEF_FRAC, 10, coefficient fraction bits (1.0 = 1024).
- ACC_W, 27, signed accumulator width; must be ≥ DATA_W+COEF_W+3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enb  in  1  global clock enable; when low, all registers hold
- in_valid  in  1  one-cycle strobe: taps valid (slow-rate enable)
- x0  in  DATA_W  x[n], signed
- x1  in  DATA_W  x[n-1], signed
- x2  in  DATA_W  x[n-2], signed
- b0, b1, b2, a1, a2  in  COEF_W each  static signed coefficients
- y_out  out  DATA_W  filtered sample, signed En3
- out_valid  out  1  one-cycle strobe: y_out updated
- busy  out  1  computation in progress
- drop  out  1  sticky: in_valid arrived while not IDLE

Behaviour:
- Reset (async, immediate): y_out=0, out_valid=0, busy=0, drop=0, y1=y2=0, acc=0, state=IDLE, product index=0.
- All sequential updates are qualified by enb=1. in_valid is sampled only when enb=1.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_valid=1 at edge T: latch x0,x1,x2, snapshot y1,y2; acc←0; idx←0; go to MAC.
- MAC:
  - One product per cycle, accumulated in full precision (no truncation).
  - Order by idx: 0:+b0·x0, 1:+b1·x1, 2:+b2·x2, 3:−a1·y1, 4:−a2·y2.
  - After the last product, go to OUT.
- OUT (one cycle):
  - r = (acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC, i.e. round half toward +inf.
  - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−1024, 1023].
  - y_out←r; out_valid=1; y2←y1; y1←r; go to IDLE.
- Latency: in_valid at edge T → out_valid high in the cycle after edge T+6 (5 MAC edges T+1..T+5, OUT result registered at T+6). Throughput: one sample per 7 cycles.
- busy=1 whenever state≠IDLE.
- in_valid while busy: sample ignored, drop←1. Only reset clears drop.
- in_valid coincident with the OUT cycle is also dropped.
- y_out holds its value between out_valid strobes.
- out_valid is exactly one enabled cycle wide.
- Coefficients are sampled each MAC cycle. Changing them mid-computation is undefined. The bench keeps them static.
- Reset mid-computation: abort immediately, all state per the reset list, no out_valid.
- enb low mid-computation: freeze; resume on the same idx when enb returns.

Optional Feature:
- IIR_FEEDBACK_EN:
  - Defined: full biquad as above, 5 MAC cycles, y1/y2 state kept.
  - Undefined: FIR only. MAC runs idx 0..2 (3 cycles), a1/a2 ports ignored, y1/y2 registers removed, latency becomes T+4.

Test Plan:
- Passthrough: b0=1024, others 0, in_valid with x0=8 → out_valid after 7 cycles, y_out=8, busy high 6 cycles.
- Rounding: b0=512, x0=3 → y_out=2. Same with x0=−3 → y_out=−1.
- Saturation: b0=2047, x0=1023 → y_out=1023. Same with x0=−1024 → y_out=−1024.
- Feedback: b0=1024, a1=−512, impulse x0=16 then x0=0, strobe every 8 cycles → y sequence 16, 8, 4, 2, 1, 1 (rounding limit cycle). Without IIR_FEEDBACK_EN → 16, 0, 0.
- Overrun: second in_valid 3 cycles after the first → first result unaffected, drop=1 and stays 1 until reset.
- Control: reset asserted at cycle T+3 → no out_valid, y_out=0, busy=0. enb low for 4 cycles mid-MAC → out_valid delayed exactly 4 cycles, value unchanged.
